// File: rtl/sc_scaled_add_ctrl.sv
// Sequencer for a stochastic scaled adder: generates a/b/sel bitstreams for 2^W cycles
// from latched binary operands and counts ones in the adder's returned stream.
`timescale 1ns/1ps
module sc_scaled_add_ctrl #(
  parameter int unsigned     W         = 8,
  parameter logic [W-1:0]    LFSR_TAPS = 8'hB8,
  parameter logic [W-1:0]    LFSR_SEED = 8'h01
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] op_a,
  input  logic [W-1:0] op_b,
  input  logic [W-1:0] sel_weight,
  output logic         a_bit,
  output logic         b_bit,
  output logic         sel_bit,
  output logic         stream_valid,
  input  logic         res_bit,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] result
);

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

  state_e       state_q, state_d;
  logic [W-1:0] idx_q, idx_d;
  logic [W-1:0] lfsr_q, lfsr_d;
  logic [W-1:0] ones_q, ones_d;
  logic [W-1:0] opa_q, opb_q, selw_q;
  logic         latch_en;
  logic [W-1:0] idx_rev;

  // Bit-reversed index gives a low-discrepancy sequence shared by a and b.
  always_comb begin
    for (int i = 0; i < int'(W); i++) begin
      idx_rev[i] = idx_q[int'(W) - 1 - i];
    end
  end

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    lfsr_d       = lfsr_q;
    ones_d       = ones_q;
    latch_en     = 1'b0;
    a_bit        = 1'b0;
    b_bit        = 1'b0;
    sel_bit      = 1'b0;
    stream_valid = 1'b0;
    done         = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d  = StRun;
          idx_d    = '0;
          lfsr_d   = LFSR_SEED;
          ones_d   = '0;
          latch_en = 1'b1;
        end
      end
      StRun: begin
        a_bit        = (idx_rev < opa_q);
        b_bit        = (idx_rev < opb_q);
        sel_bit      = (lfsr_q <= selw_q);
        stream_valid = 1'b1;
        lfsr_d       = {lfsr_q[W-2:0], ^(lfsr_q & LFSR_TAPS)};
        idx_d        = idx_q + W'(1);
        // Adder output lags its inputs by one cycle, so nothing valid to count at k=0.
        if (idx_q != '0) ones_d = ones_q + W'(res_bit);
        if (idx_q == '1) state_d = StDrain;
      end
      StDrain: begin
        ones_d  = ones_q + W'(res_bit);
        state_d = StDone;
      end
      StDone: begin
        done    = 1'b1;
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      idx_q   <= '0;
      lfsr_q  <= LFSR_SEED;
      ones_q  <= '0;
      opa_q   <= '0;
      opb_q   <= '0;
      selw_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      lfsr_q  <= lfsr_d;
      ones_q  <= ones_d;
      if (latch_en) begin
        opa_q  <= op_a;
        opb_q  <= op_b;
        selw_q <= sel_weight;
      end
    end
  end

  assign busy   = (state_q != StIdle);
  // Ones counter is cleared only on an accepted start, so it holds the result until then.
  assign result = ones_q;

endmodule

// File: tb/tb_sc_scaled_add_ctrl.sv
// Self-checking bench for sc_scaled_add_ctrl with a behavioural scaled-adder model.
`timescale 1ns/1ps
module tb_sc_scaled_add_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] op_a, op_b, sel_weight;
  logic       a_bit, b_bit, sel_bit, stream_valid, res_bit, busy, done;
  logic [7:0] result;

  int checks = 0;
  int errors = 0;

  logic ea [256];
  logic eb [256];
  logic es [256];
  int   exp_res;

  sc_scaled_add_ctrl #(.W(8), .LFSR_TAPS(8'hB8), .LFSR_SEED(8'h01)) dut (
    .clk(clk), .rst(rst), .start(start), .op_a(op_a), .op_b(op_b),
    .sel_weight(sel_weight), .a_bit(a_bit), .b_bit(b_bit), .sel_bit(sel_bit),
    .stream_valid(stream_valid), .res_bit(res_bit), .busy(busy), .done(done),
    .result(result)
  );

  always #5 clk = ~clk;

  // Scaled adder: registered 2:1 mux.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) res_bit <= 1'b0;
    else     res_bit <= sel_bit ? b_bit : a_bit;
  end

  // Expected streams and ones count for one run.
  task automatic build_ref(input logic [7:0] a, input logic [7:0] b, input logic [7:0] w);
    logic [7:0] l;
    logic [7:0] r;
    logic       fb;
    l = 8'h01;
    exp_res = 0;
    for (int k = 0; k < 256; k++) begin
      for (int j = 0; j < 8; j++) r[j] = k[7-j];
      ea[k] = (r < a);
      eb[k] = (r < b);
      es[k] = (l <= w);
      exp_res += es[k] ? int'(eb[k]) : int'(ea[k]);
      fb = l[7] ^ l[5] ^ l[4] ^ l[3];
      l  = {l[6:0], fb};
    end
  endtask

  // Watches one run whose start was accepted at the posedge just before this call.
  task automatic monitor(input string name, input logic [7:0] na, input logic [7:0] nb,
                         input logic [7:0] nw, output logic [7:0] res);
    int lat  = 0;
    int vcnt = 0;
    int serr = 0;
    int berr = 0;
    res = 8'h00;
    for (int cyc = 1; cyc <= 300; cyc++) begin
      @(negedge clk);
      if (cyc <= 256) begin
        if ({a_bit, b_bit, sel_bit, stream_valid} !== {ea[cyc-1], eb[cyc-1], es[cyc-1], 1'b1})
          serr++;
      end else if ({a_bit, b_bit, sel_bit, stream_valid} !== 4'b0000) serr++;
      if (stream_valid === 1'b1) vcnt++;
      if (busy !== (cyc <= 258)) berr++;
      if (done !== (cyc == 258)) berr++;
      if (done === 1'b1 && lat == 0) begin
        lat = cyc;
        res = result;
      end
      if (cyc >= 257) begin
        op_a = na; op_b = nb; sel_weight = nw;
      end else begin
        op_a = 8'($urandom); op_b = 8'($urandom); sel_weight = 8'($urandom);
      end
      if (lat != 0 && cyc == lat + 1) break;
    end
    checks++;
    if (lat != 258) begin
      errors++; $display("FAIL %s latency: got %0d want 258", name, lat);
    end
    checks++;
    if (vcnt != 256) begin
      errors++; $display("FAIL %s valid_cycles: got %0d want 256", name, vcnt);
    end
    checks++;
    if (serr != 0) begin
      errors++; $display("FAIL %s streams: got %0d bad cycles want 0", name, serr);
    end
    checks++;
    if (berr != 0) begin
      errors++; $display("FAIL %s busy_done: got %0d bad cycles want 0", name, berr);
    end
    checks++;
    if (int'(res) != exp_res) begin
      errors++; $display("FAIL %s result: got %0d want %0d", name, res, exp_res);
    end
  endtask

  task automatic do_run(input string name, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] w, output logic [7:0] res);
    build_ref(a, b, w);
    @(negedge clk);
    op_a = a; op_b = b; sel_weight = w; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    monitor(name, 8'($urandom), 8'($urandom), 8'($urandom), res);
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; op_a = '0; op_b = '0; sel_weight = '0;
    repeat (2) @(negedge clk);
    checks++;
    if ({a_bit, b_bit, sel_bit, stream_valid, busy, done, result} !== 14'h0) begin
      errors++; $display("FAIL reset_outputs: got %b want 0",
                         {a_bit, b_bit, sel_bit, stream_valid, busy, done, result});
    end
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, done, stream_valid} !== 3'b000) begin
      errors++; $display("FAIL idle_after_reset: got %b want 000", {busy, done, stream_valid});
    end
  endtask

  task automatic test_exact();
    logic [7:0] r;
    do_run("sel0", 8'd100, 8'd200, 8'd0, r);
    checks++;
    if (r !== 8'd100) begin errors++; $display("FAIL sel0_value: got %0d want 100", r); end
    do_run("sel255", 8'd100, 8'd200, 8'd255, r);
    checks++;
    if (r !== 8'd200) begin errors++; $display("FAIL sel255_value: got %0d want 200", r); end
    do_run("equal_ops", 8'd77, 8'd77, 8'd128, r);
    checks++;
    if (r !== 8'd77) begin errors++; $display("FAIL equal_ops_value: got %0d want 77", r); end
  endtask

  task automatic test_mid_mix();
    logic [7:0] r1, r2;
    do_run("mix1", 8'd0, 8'd255, 8'd128, r1);
    checks++;
    if (r1 < 8'd120 || r1 > 8'd136) begin
      errors++; $display("FAIL mix_range: got %0d want 120..136", r1);
    end
    do_run("mix2", 8'd0, 8'd255, 8'd128, r2);
    checks++;
    if (r2 !== r1) begin errors++; $display("FAIL mix_repeat: got %0d want %0d", r2, r1); end
  endtask

  task automatic test_random();
    logic [7:0] r, a, b, w;
    for (int i = 0; i < 4; i++) begin
      a = 8'($urandom); b = 8'($urandom); w = 8'($urandom);
      do_run($sformatf("rand%0d", i), a, b, w, r);
    end
  endtask

  task automatic test_start_held();
    logic [7:0] r;
    build_ref(8'd30, 8'd220, 8'd0);
    @(negedge clk);
    op_a = 8'd30; op_b = 8'd220; sel_weight = 8'd0; start = 1'b1;
    @(posedge clk);
    // Operands scrambled during the run; next run's operands set from the drain cycle on.
    monitor("held1", 8'd60, 8'd10, 8'd255, r);
    checks++;
    if (r !== 8'd30) begin errors++; $display("FAIL held1_value: got %0d want 30", r); end
    build_ref(8'd60, 8'd10, 8'd255);
    monitor("held2", 8'd0, 8'd0, 8'd0, r);
    checks++;
    if (r !== 8'd10) begin errors++; $display("FAIL held2_value: got %0d want 10", r); end
    start = 1'b0;
    repeat (300) @(negedge clk);
  endtask

  task automatic test_reset_midrun();
    logic [7:0] r;
    int         dcnt = 0;
    @(negedge clk);
    op_a = 8'd90; op_b = 8'd40; sel_weight = 8'd255; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (51) @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if ({a_bit, b_bit, sel_bit, stream_valid, busy, done, result} !== 14'h0) begin
      errors++; $display("FAIL midrun_reset_outputs: got %b want 0",
                         {a_bit, b_bit, sel_bit, stream_valid, busy, done, result});
    end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (done !== 1'b0 || busy !== 1'b0) dcnt++;
    end
    checks++;
    if (dcnt != 0) begin errors++; $display("FAIL no_done_after_reset: got %0d want 0", dcnt); end
    do_run("after_reset", 8'd90, 8'd40, 8'd255, r);
    checks++;
    if (r !== 8'd40) begin errors++; $display("FAIL after_reset_value: got %0d want 40", r); end
  endtask

  initial begin
    test_reset();
    test_exact();
    test_mid_mix();
    test_random();
    test_start_held();
    test_reset_midrun();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
